// File: rtl/tt_checker_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_checker_pkg;

  localparam int unsigned TT_MAX_TABLE_W = 4096;
  localparam int unsigned TT_MAX_OUT_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  // Expected output for vector k; only the low n_out bits are meaningful.
  function automatic logic [TT_MAX_OUT_W-1:0] exp_slice(
    input logic [TT_MAX_TABLE_W-1:0] tbl,
    input int unsigned               k,
    input int unsigned               n_out
  );
    return TT_MAX_OUT_W'(tbl >> (k * n_out)) & ~({TT_MAX_OUT_W{1'b1}} << n_out);
  endfunction

endpackage

// File: rtl/truth_table_checker.sv
// Sweeps every input vector onto a combinational DUT and checks each sampled
// output against a truth table captured at start.
module truth_table_checker
  import tt_checker_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [(1<<N_IN)*N_OUT-1:0]    exp_table,
  input  logic [N_OUT-1:0]              dut_out,
  output logic [N_IN-1:0]               dut_in,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 err_count,
  output logic                          first_fail_valid,
  output logic [N_IN-1:0]               first_fail_vec,
  output logic                          sample_valid,
  output logic [N_IN-1:0]               sample_vec,
  output logic                          sample_match
);

  localparam int unsigned TABLE_W = (1 << N_IN) * N_OUT;
  localparam int unsigned CNT_W   = $clog2(SETTLE) + 1;
  localparam int unsigned ERR_W   = N_IN + 1;

  tt_state_e           state_q, state_d;
  logic [TABLE_W-1:0]  exp_q, exp_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic [CNT_W-1:0]    settle_q, settle_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                ffv_q, ffv_d;
  logic [N_IN-1:0]     ffvec_q, ffvec_d;
  logic                sv_q, sv_d;
  logic [N_IN-1:0]     svec_q, svec_d;
  logic                smatch_q, smatch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_OUT-1:0]    exp_val;
  logic                match;

  // Next-state and result update
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    dut_in_d = dut_in_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    sv_d     = 1'b0;
    svec_d   = svec_q;
    smatch_d = smatch_q;
    exp_val  = N_OUT'(exp_slice(TT_MAX_TABLE_W'(exp_q), 32'(dut_in_q), N_OUT));
    match    = (dut_out == exp_val);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SWEEP;
          exp_d    = exp_table;
          dut_in_d = '0;
          settle_d = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q == CNT_W'(SETTLE - 1)) begin
          sv_d     = 1'b1;
          svec_d   = dut_in_q;
          smatch_d = match;
          if (!match) begin
            err_d = err_q + ERR_W'(1);
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = dut_in_q;
            end
          end
          if (dut_in_q == {N_IN{1'b1}}) begin
            state_d = DONE;
          end else begin
            dut_in_d = dut_in_q + N_IN'(1);
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SWEEP);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      dut_in_q <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      sv_q     <= 1'b0;
      svec_q   <= '0;
      smatch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      dut_in_q <= dut_in_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      sv_q     <= sv_d;
      svec_q   <= svec_d;
      smatch_q <= smatch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign sample_valid     = sv_q;
  assign sample_vec       = svec_q;
  assign sample_match     = smatch_q;

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking sweeper for small combinational blocks. It drives every input vector 0..2^N_IN−1 onto a DUT in order, waits a fixed settle time, then samples the DUT outputs. Each sample is compared against an expected truth table captured at start, and the block reports the mismatch count and the first failing vector. It sits in the example testbenches in place of the free-running stimulus counter and `$display` monitor, so benches pass or fail on their own.

## Interface
Parameters:
- `N_IN`, 3, DUT input width; sweep length 2^N_IN vectors
- `N_OUT`, 2, DUT output width
- `SETTLE`, 1, cycles each vector is held before sampling; legal range ≥1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin sweep; honoured only in IDLE or DONE
- `abort`  in  1  synchronous; ends a sweep, returns to IDLE
- `exp_table`  in  2^N_IN*N_OUT  expected outputs; slice `[k*N_OUT +: N_OUT]` is the expected output for vector k
- `dut_out`  in  N_OUT  outputs from the DUT
- `dut_in`  out  N_IN  registered vector driven to the DUT
- `busy`  out  1  high in SWEEP
- `done`  out  1  high in DONE
- `pass`  out  1  done && err_count==0
- `err_count`  out  N_IN+1  number of mismatching vectors
- `first_fail_valid`  out  1  at least one mismatch seen this sweep
- `first_fail_vec`  out  N_IN  vector of the first mismatch
- `sample_valid`  out  1  one-cycle pulse per compared vector
- `sample_vec`, `sample_match`  out  N_IN, 1  vector and result of that compare

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE/DONE with `start`=1: on the next edge, capture `exp_table` into an internal register and set `dut_in`=0, settle_cnt=0, err_count=0, first_fail_valid=0, first_fail_vec=0. Then go to SWEEP.
- SWEEP, each edge:
  - If settle_cnt==SETTLE−1, compare `dut_out` with the captured slice for `dut_in`.
  - Pulse `sample_valid` with `sample_vec`=`dut_in`.
  - On mismatch, increment err_count. If first_fail_valid=0, latch first_fail_vec=`dut_in` and set first_fail_valid.
  - If `dut_in`==2^N_IN−1, go to DONE with `dut_in` held. Otherwise increment `dut_in` and clear settle_cnt.
  - If settle_cnt≠SETTLE−1, increment settle_cnt.
- `start` in SWEEP is ignored. `abort` in SWEEP has priority over the compare on that edge: no sample is taken and the FSM goes to IDLE. Results are kept, `done`=0.
- DONE holds all results until a new `start`.
- err_count cannot overflow, since its maximum value is 2^N_IN.

## Timing
- Reset (async assert, deassert synchronised by the bench): state IDLE and every output 0, including `dut_in`, `pass`, `err_count`, `first_fail_*` and `sample_*`.
- Reset mid-sweep aborts immediately with no partial results kept.
- Start accepted at edge E0. Vector k is driven from E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
- `done` rises after edge E0+2^N_IN·SETTLE; `busy` falls on the same edge.
- `sample_valid` is registered and is high in the cycle following its compare edge.
- `dut_out` must settle within SETTLE cycles of `dut_in` changing. The DUT is purely combinational, so SETTLE=1 suffices.
- `exp_table` changes after E0 have no effect on the current sweep.

## Structure
- Shared package `tt_checker_pkg`: state enum `tt_state_e` {IDLE, SWEEP, DONE}, and helper function `exp_slice(table, k)` returning the N_OUT-bit expected value.
- Single module, no sub-module. Settle counter width is $clog2(SETTLE)+1.

## Test plan
For these scenarios, N_IN=3 and N_OUT=2. The DUT is `intermediate_signal`: in_1=`dut_in[0]`, in_2=`dut_in[1]`, in_3=`dut_in[2]`, and `dut_out`={out_2,out_1}. The correct table is `exp_table`=16'hEA80.
- Reset: assert `rst_n`=0 mid-cycle → all outputs 0 immediately. Release and hold `start`=0 → IDLE, outputs stay 0.
- Correct DUT, SETTLE=1, `start` pulse at E0 → `dut_in` steps 0..7, eight `sample_match`=1 pulses. `done`=`pass`=1 after E0+8, err_count=0.
- out_1 stuck at 0 → err_count=1, first_fail_vec=7, `pass`=0.
- `exp_table`=16'h0000 with correct DUT → err_count=5, first_fail_vec=3.
- SETTLE=2 → each vector held 2 cycles, `done` after E0+16. `start` asserted during SWEEP is ignored.
- `abort` at E0+4, then restart → FSM in IDLE, `done`=0. A fresh sweep clears results and reruns to `pass`=1. A separate run with `rst_n` asserted at E0+3 returns to reset values.
